// File: rtl/sounder_capture_ctrl.sv
// rtl/sounder_capture_ctrl.sv - triggered snapshot capture and ready/valid readout over a dual-port RAM
// Optional macro SOUNDER_CAP_TS_EN builds a free-running cycle counter latched into cap_ts on trigger.
module sounder_capture_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [AWIDTH-1:0] cap_len,
  input  logic [DWIDTH-1:0] i_tdata,
  input  logic              i_tvalid,
  output logic [DWIDTH-1:0] o_tdata,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              o_tlast,
  output logic              busy,
  output logic              done,
  output logic [63:0]       cap_ts,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_w_addr,
  output logic [AWIDTH-1:0] mem_r_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  // Top address is a guard slot that absorbs the don't-care writes during readout.
  localparam logic [AWIDTH-1:0] GUARD = '1;
  localparam logic [AWIDTH-1:0] ONE   = AWIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_READOUT} state_t;

  state_t            state, state_d;
  logic [AWIDTH-1:0] len, len_d;
  logic [AWIDTH-1:0] wr_cnt, wr_cnt_d;
  logic [AWIDTH-1:0] iss_cnt, iss_cnt_d;
  logic [AWIDTH-1:0] rd_cnt, rd_cnt_d;
  logic              tvalid_q, tvalid_d;
  logic              done_d;
  logic              issue;
  logic              beat;
  logic              trig_acc;

  assign o_tdata  = mem_dout;
  assign o_tvalid = tvalid_q;
  assign o_tlast  = tvalid_q && (rd_cnt == len - ONE);
  assign busy     = (state != S_IDLE);
  assign mem_din  = i_tdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len      <= GUARD;
      wr_cnt   <= '0;
      iss_cnt  <= '0;
      rd_cnt   <= '0;
      tvalid_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      len      <= len_d;
      wr_cnt   <= wr_cnt_d;
      iss_cnt  <= iss_cnt_d;
      rd_cnt   <= rd_cnt_d;
      tvalid_q <= tvalid_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    len_d      = len;
    wr_cnt_d   = wr_cnt;
    iss_cnt_d  = iss_cnt;
    rd_cnt_d   = rd_cnt;
    tvalid_d   = tvalid_q;
    done_d     = 1'b0;
    mem_en     = 1'b0;
    mem_w_addr = wr_cnt;
    mem_r_addr = '0;
    issue      = 1'b0;
    beat       = 1'b0;
    trig_acc   = 1'b0;

    case (state)
      S_IDLE: begin
        if (arm) begin
          state_d  = S_ARMED;
          len_d    = ((cap_len == '0) || (cap_len == GUARD)) ? GUARD : cap_len;
          wr_cnt_d = '0;
        end
      end

      S_ARMED: begin
        if (trigger) begin
          trig_acc = 1'b1;
          state_d  = S_CAPTURE;
          // The trigger-cycle sample is the first one stored.
          if (i_tvalid) begin
            mem_en   = 1'b1;
            wr_cnt_d = ONE;
            if (len == ONE) begin
              state_d   = S_READOUT;
              iss_cnt_d = '0;
              rd_cnt_d  = '0;
            end
          end
        end
      end

      S_CAPTURE: begin
        mem_en = i_tvalid;
        if (i_tvalid) begin
          wr_cnt_d = wr_cnt + ONE;
          if (wr_cnt == len - ONE) begin
            state_d   = S_READOUT;
            iss_cnt_d = '0;
            rd_cnt_d  = '0;
          end
        end
      end

      S_READOUT: begin
        mem_w_addr = GUARD;
        mem_r_addr = iss_cnt;
        beat       = tvalid_q && o_tready;
        issue      = (iss_cnt < len) && (!tvalid_q || o_tready);
        // mem_en low on a stall keeps the RAM output register, and so o_tdata, frozen.
        if (issue) begin
          mem_en    = 1'b1;
          iss_cnt_d = iss_cnt + ONE;
          tvalid_d  = 1'b1;
        end else if (beat) begin
          tvalid_d = 1'b0;
        end
        if (beat) begin
          rd_cnt_d = rd_cnt + ONE;
          if (rd_cnt == len - ONE) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            tvalid_d = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      tvalid_d = 1'b0;
      done_d   = 1'b0;
      mem_en   = 1'b0;
      trig_acc = 1'b0;
    end
  end

`ifdef SOUNDER_CAP_TS_EN
  logic [63:0] ts_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt <= '0;
      cap_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 64'd1;
      if (trig_acc) cap_ts <= ts_cnt;
    end
  end
`else
  assign cap_ts = '0;
`endif

endmodule

// File: doc/sounder_capture_ctrl.md
Name: sounder_capture_ctrl

Overview:
- Sequences one simple dual-port block RAM as a triggered snapshot buffer in the sounder RX path.
- On arm plus trigger, writes a programmed number of incoming samples into the RAM, then streams them out on a ready/valid interface with tlast.
- Drives the RAM's single combined enable, which gates both write and read, so write and read phases never overlap in a harmful way.
- Instantiated beside the RAM and clocked in the RFNoC compute-engine domain.

Parameters:
- DWIDTH, 32, sample/RAM data width.
- AWIDTH, 10, RAM address width. DEPTH = 2**AWIDTH. Address DEPTH-1 is a reserved guard slot, so max capture length is DEPTH-1.

Ports:
- clk  in  1  single clock; drives both RAM clocks.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle start request; honoured only in IDLE.
- abort  in  1  return to IDLE from any state.
- trigger  in  1  capture start condition; sampled in ARMED.
- cap_len  in  AWIDTH  number of samples to capture; sampled on accepted arm.
- i_tdata  in  DWIDTH  input sample.
- i_tvalid  in  1  input sample strobe; no backpressure.
- o_tdata  out  DWIDTH  readout sample; wired directly to mem_dout.
- o_tvalid  out  1  readout valid.
- o_tready  in  1  readout ready.
- o_tlast  out  1  marks the final readout sample.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the last beat is accepted.
- cap_ts  out  64  trigger timestamp (see Optional Feature).
- mem_en  out  1  RAM combined enable.
- mem_w_addr  out  AWIDTH  RAM write address.
- mem_r_addr  out  AWIDTH  RAM read address.
- mem_din  out  DWIDTH  RAM write data.
- mem_dout  in  DWIDTH  RAM read data; registered in the RAM, 1-cycle latency, held while mem_en is low.

Behaviour:
- Reset values: state IDLE; busy, done, o_tvalid, o_tlast, mem_en all 0; all addresses 0; cap_ts 0.
- Length latch: len = cap_len, except 0 or DEPTH-1 or greater is clamped to DEPTH-1.
- mem_din = i_tdata at all times.

States:
- IDLE
  - arm -> ARMED; latch len. Arm is never ignored here.
  - A trigger in the same cycle as arm is not seen.
- ARMED
  - mem_en = 0.
  - trigger -> CAPTURE.
  - The trigger-cycle sample is the first sample captured: if i_tvalid, it is written to address 0 and wr_cnt = 1.
- CAPTURE
  - mem_en = i_tvalid; mem_w_addr = wr_cnt.
  - Each valid sample increments wr_cnt.
  - When the write of sample len-1 occurs -> READOUT, with rd_cnt = 0 and iss_cnt = 0 next cycle.
  - Trigger is ignored here.
- READOUT
  - mem_w_addr = DEPTH-1 (guard slot); writes there are harmless.
  - mem_r_addr = iss_cnt.
  - Issue condition: (iss_cnt < len) and (!o_tvalid or o_tready). When it holds, mem_en = 1, iss_cnt increments, and o_tvalid = 1 next cycle.
  - When o_tvalid and o_tready and no issue occurs: o_tvalid -> 0.
  - o_tlast = o_tvalid and (rd_cnt == len-1). rd_cnt increments on each accepted beat.
  - Last beat accepted -> IDLE, done = 1 for one cycle.
  - While stalled, mem_en = 0, so o_tdata holds stable.
- Abort: in any state, next cycle goes to IDLE, o_tvalid = 0, mem_en = 0, no done pulse. abort has priority over arm, trigger and handshake in the same cycle.
- Latencies:
  - First o_tvalid appears 2 cycles after the final capture write (1 cycle state change, 1 cycle RAM latency).
  - Full throughput of 1 beat/cycle while o_tready is held high.
- Reset mid-operation: immediate return to reset values; RAM contents are undefined to the user.

Optional Feature:
- Macro: SOUNDER_CAP_TS_EN.
- Defined: a 64-bit free-running cycle counter, reset to 0, increments every clk. On the trigger-accept cycle its value is latched into cap_ts, which holds until the next trigger accept.
- Undefined: no counter is built; cap_ts is tied to 0.

Test Plan:
- cap_len=4; arm; trigger with i_tvalid continuous, data 0xA0..0xA3; o_tready=1 -> o_tdata A0,A1,A2,A3 on consecutive cycles, o_tlast on A3, done pulse, then IDLE.
- Same as above, but i_tvalid toggles 1,0,1,0 -> only valid samples are captured, in order, and the readout count is exactly 4.
- Readout with o_tready low for 3 cycles on beat 2 -> o_tdata and o_tvalid held steady, no duplicated or lost beats, mem_en low during the stall.
- cap_len=0 with AWIDTH=4 -> 15 samples captured and read; guard address 15 is never read; readout data is uncorrupted.
- abort asserted mid-CAPTURE and again mid-READOUT -> next cycle busy=0, o_tvalid=0, no done; a subsequent arm/trigger sequence works normally.
- SOUNDER_CAP_TS_EN defined; trigger at cycle 100 after reset -> cap_ts = 100; undefined -> cap_ts = 0.
